// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot path: loader state encoding,
// default watchdog limit and the memory byte width.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int BYTE_W          = 8;

endpackage

// File: rtl/imem_boot_loader.sv
// Streams bytes into instruction memory from address 0 and holds the core in reset until loaded.
// Latency: 1 cycle accept->mem_we; backpressure: byte_ready low outside LOAD or while start is high.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int N       = 9,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N:0]        load_len,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [N-1:0]      mem_wa,
    output logic [BYTE_W-1:0] mem_wd,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [BYTE_W-1:0] checksum
);

    localparam int           WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [N:0]   MAX_LEN = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   ONE_LEN = {{N{1'b0}}, 1'b1};
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [N-1:0]    addr;
    logic [N:0]      remaining;
    logic [WD_W-1:0] wdog;
    logic            accept;
    logic            last_byte;
    logic            wd_expire;

    assign byte_ready = (state == LOAD) && !start;
    assign accept     = byte_valid && byte_ready;
    assign last_byte  = (remaining == ONE_LEN);
    // An idle cycle that brings the watchdog up to TIMEOUT is the one that errors out.
    assign wd_expire  = !accept && (wdog >= WD_LAST);

    assign busy  = (state == LOAD);
    assign done  = (state == DONE);
    assign error = (state == ERR);

    always_comb begin
        state_nxt = state;
        if (start) begin
            if (load_len > MAX_LEN) begin
                state_nxt = ERR;
            end else if (load_len == '0) begin
                state_nxt = DONE;
            end else begin
                state_nxt = LOAD;
            end
        end else if (state == LOAD) begin
            if (accept && last_byte) begin
                state_nxt = DONE;
            end else if (wd_expire) begin
                state_nxt = ERR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            wdog       <= '0;
            checksum   <= '0;
            mem_we     <= 1'b0;
            mem_wa     <= '0;
            mem_wd     <= '0;
            core_rst_n <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_we     <= accept;
            // Core leaves reset only after the final write has been presented to memory.
            core_rst_n <= (state == DONE);
            if (accept) begin
                mem_wa <= addr;
                mem_wd <= byte_in;
            end
            if (start) begin
                addr      <= '0;
                remaining <= load_len;
                checksum  <= '0;
                wdog      <= '0;
            end else if (state == LOAD) begin
                if (accept) begin
                    checksum  <= checksum ^ byte_in;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    wdog      <= '0;
                end else if (wdog != WD_MAX) begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule
